// File: rtl/i2c_slave_reg_responder.sv
// I2C register-port slave at SLAVE_ADDR: oversampled SCL/SDA, pointer write, auto-incrementing reads.
// Wire edge -> event in 3 cycles, event -> sda_oe/strobes +1 cycle; open-drain SDA, no clock stretching.
module i2c_slave_reg_responder #(
  parameter logic [6:0] SLAVE_ADDR = 7'h68
) (
  input  logic       clk_200khz,
  input  logic       rst,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  input  logic [7:0] reg_rdata,
  output logic [7:0] reg_wdata,
  output logic       reg_wr_en,
  output logic       rd_strobe,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_BYTE,
    ST_WR_ACK,
    ST_RD_BYTE,
    ST_RD_ACK,
    ST_IGNORE
  } state_t;

  logic [1:0] scl_sync_q, scl_sync_d;
  logic [1:0] sda_sync_q, sda_sync_d;
  logic       scl_prev_q, scl_prev_d;
  logic       sda_prev_q, sda_prev_d;
  logic       ev_rise_q, ev_rise_d;
  logic       ev_fall_q, ev_fall_d;
  logic       ev_start_q, ev_start_d;
  logic       ev_stop_q, ev_stop_d;
  state_t     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] tx_q, tx_d;
  logic       rw_q, rw_d;
  logic       first_byte_q, first_byte_d;
  logic       ack_stage_q, ack_stage_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] reg_addr_q, reg_addr_d;
  logic [7:0] reg_wdata_q, reg_wdata_d;
  logic       reg_wr_en_q, reg_wr_en_d;
  logic       rd_strobe_q, rd_strobe_d;
  logic       busy_q, busy_d;

  logic [7:0] rx_shift;
  logic       load_tx;

  // Events are registered, so sda_prev_q is the SDA level aligned with the event being acted on.
  always_comb begin
    scl_sync_d = {scl_sync_q[0], scl};
    sda_sync_d = {sda_sync_q[0], sda_in};
    scl_prev_d = scl_sync_q[1];
    sda_prev_d = sda_sync_q[1];
    ev_rise_d  = scl_sync_q[1] & ~scl_prev_q;
    ev_fall_d  = ~scl_sync_q[1] & scl_prev_q;
    ev_start_d = scl_sync_q[1] & scl_prev_q & ~sda_sync_q[1] & sda_prev_q;
    ev_stop_d  = scl_sync_q[1] & scl_prev_q & sda_sync_q[1] & ~sda_prev_q;
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    rx_d         = rx_q;
    tx_d         = tx_q;
    rw_d         = rw_q;
    first_byte_d = first_byte_q;
    ack_stage_d  = ack_stage_q;
    sda_oe_d     = sda_oe_q;
    reg_addr_d   = reg_addr_q;
    reg_wdata_d  = reg_wdata_q;
    reg_wr_en_d  = 1'b0;
    rd_strobe_d  = 1'b0;
    busy_d       = busy_q;
    load_tx      = 1'b0;
    rx_shift     = {rx_q[6:0], sda_prev_q};

    // Post-write pointer bump lands the cycle after the strobe.
    if (reg_wr_en_q) begin
      reg_addr_d = reg_addr_q + 8'd1;
    end

    if (ev_start_q) begin
      state_d   = ST_ADDR;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
    end else if (ev_stop_q) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (ev_rise_q) begin
            rx_d      = rx_shift;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              if (rx_shift[7:1] == SLAVE_ADDR) begin
                state_d     = ST_ADDR_ACK;
                busy_d      = 1'b1;
                rw_d        = rx_shift[0];
                ack_stage_d = 1'b0;
              end else begin
                state_d = ST_IGNORE;
                busy_d  = 1'b0;
              end
            end
          end
        end

        ST_ADDR_ACK: begin
          if (ev_fall_q) begin
            if (!ack_stage_q) begin
              sda_oe_d    = 1'b1;
              ack_stage_d = 1'b1;
            end else if (rw_q) begin
              load_tx = 1'b1;
            end else begin
              sda_oe_d     = 1'b0;
              state_d      = ST_WR_BYTE;
              first_byte_d = 1'b1;
              bit_cnt_d    = 4'd0;
            end
          end
        end

        ST_WR_BYTE: begin
          if (ev_rise_q) begin
            rx_d      = rx_shift;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              if (first_byte_q) begin
                reg_addr_d   = rx_shift;
                first_byte_d = 1'b0;
              end else begin
                reg_wdata_d = rx_shift;
                reg_wr_en_d = 1'b1;
              end
              bit_cnt_d   = 4'd0;
              state_d     = ST_WR_ACK;
              ack_stage_d = 1'b0;
            end
          end
        end

        ST_WR_ACK: begin
          if (ev_fall_q) begin
            if (!ack_stage_q) begin
              sda_oe_d    = 1'b1;
              ack_stage_d = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              state_d   = ST_WR_BYTE;
              bit_cnt_d = 4'd0;
            end
          end
        end

        // bit_cnt counts bits already placed on the wire; bit 7 goes out at load time.
        ST_RD_BYTE: begin
          if (ev_fall_q) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d    = 1'b0;
              reg_addr_d  = reg_addr_q + 8'd1;
              state_d     = ST_RD_ACK;
              ack_stage_d = 1'b0;
              bit_cnt_d   = 4'd0;
            end else begin
              sda_oe_d  = ~tx_q[6];
              tx_d      = {tx_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end

        ST_RD_ACK: begin
          if (ev_rise_q) begin
            if (sda_prev_q) begin
              state_d = ST_IGNORE;
              busy_d  = 1'b0;
            end else begin
              ack_stage_d = 1'b1;
            end
          end else if (ev_fall_q && ack_stage_q) begin
            load_tx = 1'b1;
          end
        end

        default: ;
      endcase

      if (load_tx) begin
        tx_d        = reg_rdata;
        rd_strobe_d = 1'b1;
        sda_oe_d    = ~reg_rdata[7];
        bit_cnt_d   = 4'd1;
        state_d     = ST_RD_BYTE;
      end
    end
  end

  always_ff @(posedge clk_200khz or posedge rst) begin
    if (rst) begin
      scl_sync_q   <= 2'b11;
      sda_sync_q   <= 2'b11;
      scl_prev_q   <= 1'b1;
      sda_prev_q   <= 1'b1;
      ev_rise_q    <= 1'b0;
      ev_fall_q    <= 1'b0;
      ev_start_q   <= 1'b0;
      ev_stop_q    <= 1'b0;
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 4'd0;
      rx_q         <= 8'h00;
      tx_q         <= 8'h00;
      rw_q         <= 1'b0;
      first_byte_q <= 1'b0;
      ack_stage_q  <= 1'b0;
      sda_oe_q     <= 1'b0;
      reg_addr_q   <= 8'h00;
      reg_wdata_q  <= 8'h00;
      reg_wr_en_q  <= 1'b0;
      rd_strobe_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      scl_sync_q   <= scl_sync_d;
      sda_sync_q   <= sda_sync_d;
      scl_prev_q   <= scl_prev_d;
      sda_prev_q   <= sda_prev_d;
      ev_rise_q    <= ev_rise_d;
      ev_fall_q    <= ev_fall_d;
      ev_start_q   <= ev_start_d;
      ev_stop_q    <= ev_stop_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      rx_q         <= rx_d;
      tx_q         <= tx_d;
      rw_q         <= rw_d;
      first_byte_q <= first_byte_d;
      ack_stage_q  <= ack_stage_d;
      sda_oe_q     <= sda_oe_d;
      reg_addr_q   <= reg_addr_d;
      reg_wdata_q  <= reg_wdata_d;
      reg_wr_en_q  <= reg_wr_en_d;
      rd_strobe_q  <= rd_strobe_d;
      busy_q       <= busy_d;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_wr_en = reg_wr_en_q;
  assign rd_strobe = rd_strobe_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_slave_reg_responder.sv
// Bench for i2c_slave_reg_responder: bit-level bus master, host register file, transaction-level model.
`timescale 1ns/1ps
module tb_i2c_slave_reg_responder;

  logic       clk_200khz = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] reg_addr;
  logic [7:0] reg_rdata;
  logic [7:0] reg_wdata;
  logic       reg_wr_en;
  logic       rd_strobe;
  logic       busy;

  i2c_slave_reg_responder dut (
    .clk_200khz(clk_200khz),
    .rst       (rst),
    .scl       (scl),
    .sda_in    (sda_in),
    .sda_oe    (sda_oe),
    .reg_addr  (reg_addr),
    .reg_rdata (reg_rdata),
    .reg_wdata (reg_wdata),
    .reg_wr_en (reg_wr_en),
    .rd_strobe (rd_strobe),
    .busy      (busy)
  );

  always #2500 clk_200khz = ~clk_200khz;

  assign sda_in = sda_m & ~sda_oe;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  function automatic logic [7:0] init_val(input int i);
    logic [7:0] v;
    v = 8'(i);
    return (v == 8'h42) ? 8'hA5 : (v ^ 8'h5A);
  endfunction

  // Host register file and activity monitor.
  logic [7:0] mem_dut [256];
  logic       mem_init_done = 1'b0;
  wr_t        act_wq [$];
  int         rd_cnt = 0;
  int         oe_cycles = 0;
  int         busy_cycles = 0;

  assign reg_rdata = mem_dut[reg_addr];

  always @(negedge clk_200khz) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 256; i++) mem_dut[i] = init_val(i);
      mem_init_done = 1'b1;
    end
    if (!rst) begin
      if (reg_wr_en) begin
        act_wq.push_back({reg_addr, reg_wdata});
        mem_dut[reg_addr] = reg_wdata;
      end
      if (rd_strobe) rd_cnt++;
      if (sda_oe) oe_cycles++;
      if (busy) busy_cycles++;
    end
  end

  // Reference model: pointer plus expected register contents.
  logic [7:0] m_mem [256];
  logic [7:0] m_ptr;
  wr_t        exp_wq [$];
  int         wr_seen;

  int n_vec = 0;
  int n_mis = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_200khz);
  endtask

  // Each bit: SCL low 10 cycles (SDA set 2 in), high 10 cycles, sampled mid-high.
  task automatic send_bit(input logic b, output logic got, output logic oe);
    cyc(2); sda_m = b;
    cyc(8); scl = 1'b1;
    cyc(5); got = sda_in; oe = sda_oe;
    cyc(5); scl = 1'b0;
  endtask

  task automatic i2c_start();
    cyc(2); sda_m = 1'b1;
    cyc(8); scl = 1'b1;
    cyc(5); sda_m = 1'b0;
    cyc(5); scl = 1'b0;
  endtask

  task automatic i2c_stop();
    cyc(2); sda_m = 1'b0;
    cyc(8); scl = 1'b1;
    cyc(5); sda_m = 1'b1;
    cyc(10);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack, output logic ack_oe);
    logic g, o;
    for (int i = 7; i >= 0; i--) send_bit(b[i], g, o);
    send_bit(1'b1, g, o);
    ack = ~g;
    ack_oe = o;
  endtask

  task automatic recv_byte(input logic master_ack, output logic [7:0] d);
    logic g, o;
    d = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, g, o);
      d[i] = g;
    end
    send_bit(~master_ack, g, o);
  endtask

  task automatic run_xfer(input logic [7:0] ab, input int nw, input logic [31:0] wb, input int nr,
                          output logic got_ack, output logic [7:0] got_rd0);
    int rd0, oe0, busy0, exp_rd, nchk;
    logic match, first, a, aoe;
    logic [7:0] b, d;
    rd0 = rd_cnt; oe0 = oe_cycles; busy0 = busy_cycles;
    exp_rd = 0; first = 1'b1; got_rd0 = 8'h00;
    match = (ab[7:1] == 7'h68);
    i2c_start();
    send_byte(ab, a, aoe);
    got_ack = a;
    check("addr_ack", a, match);
    check("addr_ack_oe", aoe, match);
    if (match) check("busy_after_addr", busy, 1);
    if (!match || !ab[0]) begin
      for (int k = 0; k < nw; k++) begin
        b = wb[31 - 8*k -: 8];
        send_byte(b, a, aoe);
        check("data_ack", a, match);
        if (match) begin
          if (first) begin
            m_ptr = b;
            first = 1'b0;
          end else begin
            exp_wq.push_back({m_ptr, b});
            m_mem[m_ptr] = b;
            m_ptr = m_ptr + 8'd1;
          end
        end
      end
    end else begin
      for (int k = 0; k < nr; k++) begin
        recv_byte(k < nr - 1, d);
        if (k == 0) got_rd0 = d;
        check("rd_data", d, m_mem[m_ptr]);
        m_ptr = m_ptr + 8'd1;
      end
      exp_rd = nr;
    end
    i2c_stop();
    check("reg_addr", reg_addr, m_ptr);
    check("busy_idle", busy, 0);
    check("rd_strobes", rd_cnt - rd0, exp_rd);
    check("wr_count", act_wq.size() - wr_seen, exp_wq.size());
    nchk = act_wq.size() - wr_seen;
    if (exp_wq.size() < nchk) nchk = exp_wq.size();
    for (int j = 0; j < nchk; j++) begin
      check("wr_addr", act_wq[wr_seen + j].a, exp_wq[j].a);
      check("wr_data", act_wq[wr_seen + j].d, exp_wq[j].d);
    end
    wr_seen = act_wq.size();
    exp_wq.delete();
    if (!match) begin
      check("mismatch_oe_quiet", oe_cycles - oe0, 0);
      check("mismatch_busy_quiet", busy_cycles - busy0, 0);
    end
  endtask

  typedef struct {
    logic [7:0]  addr_byte;
    int          nw;
    logic [31:0] wb;
    int          nr;
    logic        exp_ack;
    logic [7:0]  exp_ptr;
    int          exp_wr;
    logic [7:0]  exp_rd0;
  } vec_t;

  vec_t vecs [5];

  initial begin
    repeat (90000) @(posedge clk_200khz);
    $display("FAIL watchdog: got no completion, expected finish within 90000 cycles");
    $fatal(1, "timeout");
  end

  initial begin
    logic ga, a, o;
    logic [7:0] gr, d, ab;
    logic [31:0] wb;
    int w0, r0, kind, nw, nr;

    vecs[0] = '{8'hD0, 1, 32'h4200_0000, 0, 1'b1, 8'h42, 0, 8'h00};
    vecs[1] = '{8'hD1, 0, 32'h0000_0000, 1, 1'b1, 8'h43, 0, 8'hA5};
    vecs[2] = '{8'hD0, 3, 32'hFE11_2200, 0, 1'b1, 8'h00, 2, 8'h00};
    vecs[3] = '{8'hA0, 1, 32'h4200_0000, 0, 1'b0, 8'h00, 0, 8'h00};
    vecs[4] = '{8'hD1, 0, 32'h0000_0000, 2, 1'b1, 8'h02, 0, 8'h5A};

    for (int i = 0; i < 256; i++) m_mem[i] = init_val(i);
    m_ptr = 8'h00;
    wr_seen = 0;

    cyc(4);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_reg_addr", reg_addr, 8'h00);
    check("rst_reg_wdata", reg_wdata, 8'h00);
    check("rst_reg_wr_en", reg_wr_en, 0);
    check("rst_rd_strobe", rd_strobe, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    cyc(5);

    for (int i = 0; i < 5; i++) begin
      w0 = act_wq.size();
      run_xfer(vecs[i].addr_byte, vecs[i].nw, vecs[i].wb, vecs[i].nr, ga, gr);
      check("tbl_ack", ga, vecs[i].exp_ack);
      check("tbl_ptr", reg_addr, vecs[i].exp_ptr);
      check("tbl_wr", act_wq.size() - w0, vecs[i].exp_wr);
      if (vecs[i].nr > 0) check("tbl_rd0", gr, vecs[i].exp_rd0);
    end

    // Repeated START three bits into a write data byte, then a read from the kept pointer.
    r0 = rd_cnt;
    i2c_start();
    send_byte(8'hD0, a, o);
    check("rs_ack_wr", a, 1);
    send_bit(1'b1, a, o);
    send_bit(1'b0, a, o);
    send_bit(1'b1, a, o);
    i2c_start();
    send_byte(8'hD1, a, o);
    check("rs_ack_rd", a, 1);
    recv_byte(1'b0, d);
    check("rs_data", d, m_mem[m_ptr]);
    m_ptr = m_ptr + 8'd1;
    i2c_stop();
    check("rs_ptr", reg_addr, m_ptr);
    check("rs_strobes", rd_cnt - r0, 1);

    // Reset while the slave is pulling SDA low for a 0 data bit (mem[0x10] = 0x4A).
    run_xfer(8'hD0, 1, 32'h1000_0000, 0, ga, gr);
    r0 = rd_cnt;
    i2c_start();
    send_byte(8'hD1, a, o);
    check("rr_ack", a, 1);
    cyc(6);
    check("rr_driving_zero", sda_oe, 1);
    check("rr_strobe", rd_cnt - r0, 1);
    #1000;
    rst = 1'b1;
    #1;
    check("rr_async_oe", sda_oe, 0);
    check("rr_async_busy", busy, 0);
    cyc(2);
    check("rr_reg_addr", reg_addr, 8'h00);
    check("rr_wr_en", reg_wr_en, 0);
    check("rr_rd_strobe", rd_strobe, 0);
    scl = 1'b1;
    sda_m = 1'b1;
    cyc(3);
    rst = 1'b0;
    m_ptr = 8'h00;
    cyc(5);
    check("rr_idle_busy", busy, 0);
    check("rr_idle_oe", sda_oe, 0);

    for (int t = 0; t < 12; t++) begin
      kind = $urandom_range(0, 3);
      nw = 0; nr = 0; wb = $urandom;
      if (kind <= 1) begin
        ab = 8'hD0;
        nw = $urandom_range(1, 4);
      end else if (kind == 2) begin
        ab = 8'hD1;
        nr = $urandom_range(1, 3);
      end else begin
        ab[7:1] = 7'($urandom_range(0, 127));
        if (ab[7:1] == 7'h68) ab[7:1] = 7'h69;
        ab[0] = 1'($urandom_range(0, 1));
        nw = $urandom_range(0, 2);
      end
      run_xfer(ab, nw, wb, nr, ga, gr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
